// File: rtl/point_accum_writer_pkg.sv
// point_accum_writer_pkg
//   Shared constants, types and helpers for the pointwise accumulate/write stage.
//   LANES / CH_GROUP_SHIFT describe the 8-channel grouping of every beat,
//   acc_word_t is one slot of eight per-lane accumulators, and sat_to_data
//   clamps an accumulator value into the signed output lane range.
package point_accum_writer_pkg;

    localparam int LANES          = 8;
    localparam int CH_GROUP_SHIFT = 3;
    localparam int DATA_WIDTH     = 8;
    localparam int ACC_WIDTH      = 16;
    localparam int MAX_OC_GROUPS  = 8;
    localparam int ADDR_WIDTH     = 17;
    localparam int SLOT_WIDTH     = $clog2(MAX_OC_GROUPS);

    localparam logic signed [ACC_WIDTH-1:0] DATA_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] DATA_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef logic signed [ACC_WIDTH-1:0] acc_lane_t;
    typedef acc_lane_t [LANES-1:0]       acc_word_t;

    // Clamp an accumulator value to the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_to_data(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] c;
        if (v > DATA_MAX)
            c = DATA_MAX;
        else if (v < DATA_MIN)
            c = DATA_MIN;
        else
            c = v;
        return c[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/point_accum_writer_lane.sv
// point_acc_lane
//   One lane of the accumulator datapath (purely combinational).
//   Ports:
//     acc_prev  - stored partial sum for this lane/slot
//     lane_val  - incoming signed lane value
//     first     - beat starts a new sum (input-channel base 0)
//     relu      - clamp negative results to zero
//     sum       - new partial sum, saturated to ACC_WIDTH
//     result    - sum clamped to DATA_WIDTH, ReLU applied
module point_acc_lane
    import point_accum_writer_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc_prev,
    input  logic [DATA_WIDTH-1:0] lane_val,
    input  logic                  first,
    input  logic                  relu,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic [DATA_WIDTH-1:0] result
);

    logic [ACC_WIDTH:0]     wide;
    logic [ACC_WIDTH-1:0]   lane_ext;
    logic [DATA_WIDTH-1:0]  clamped;

    // One guard bit catches overflow: the top two bits differ only when the
    // true sum left the ACC_WIDTH signed range, and the guard bit gives the sign.
    always_comb begin
        lane_ext = {{(ACC_WIDTH - DATA_WIDTH){lane_val[DATA_WIDTH-1]}}, lane_val};
        wide     = {acc_prev[ACC_WIDTH-1], acc_prev} + {lane_ext[ACC_WIDTH-1], lane_ext};
        if (first)
            sum = lane_ext;
        else if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
            sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            sum = wide[ACC_WIDTH-1:0];
        clamped = sat_to_data(sum);
        result  = (relu && clamped[DATA_WIDTH-1]) ? '0 : clamped;
    end

endmodule

// File: rtl/point_accum_writer.sv
// point_accum_writer
//   Accumulates 8-lane beats across input-channel groups per output-channel
//   slot, then clamps/ReLUs and writes each finished word to the feature buffer.
//   Ports:
//     clk, rst                      - clock, synchronous active-high reset
//     in_valid, in_data             - beat qualifier and eight signed lanes
//     in_ic_sel, in_oc_sel          - input/output channel bases of the beat
//     in_h, in_w                    - pixel coordinate of the beat
//     input_channel, output_channel,
//     output_size, relu_en          - layer config, latched at frame start
//     wr_en, wr_addr, wr_data       - registered buffer write
//     frame_done                    - pulses with the final write of a frame
//     busy                          - frame in progress
//     seq_err                       - sticky protocol-violation flag
module point_accum_writer
    import point_accum_writer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH*LANES-1:0]   in_data,
    input  logic [7:0]                    in_ic_sel,
    input  logic [7:0]                    in_oc_sel,
    input  logic [7:0]                    in_h,
    input  logic [7:0]                    in_w,
    input  logic [7:0]                    input_channel,
    input  logic [7:0]                    output_channel,
    input  logic [7:0]                    output_size,
    input  logic                          relu_en,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH*LANES-1:0]   wr_data,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          seq_err
);

    logic [7:0]             cfg_ic;
    logic [7:0]             cfg_oc;
    logic [7:0]             cfg_size;
    logic                   cfg_relu;

    acc_word_t              acc [MAX_OC_GROUPS];
    logic [7:0]             expected_ic [MAX_OC_GROUPS];

    logic [7:0]             eff_ic;
    logic [7:0]             eff_oc;
    logic [7:0]             eff_size;
    logic                   eff_relu;
    logic [5:0]             oc_groups;
    logic                   last_ic;
    logic                   first;
    logic                   slot_ok;
    logic [SLOT_WIDTH-1:0]  slot;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic                   frame_end;
    acc_word_t              sum_word;
    logic [DATA_WIDTH*LANES-1:0] out_word;

    // The first beat of a frame must already use the port config, because
    // it may also be the last beat (1x1 single group frame).
    always_comb begin
        eff_ic    = busy ? cfg_ic   : input_channel;
        eff_oc    = busy ? cfg_oc   : output_channel;
        eff_size  = busy ? cfg_size : output_size;
        eff_relu  = busy ? cfg_relu : relu_en;
        oc_groups = 6'((9'(eff_oc) + 9'd7) >> CH_GROUP_SHIFT);
        last_ic   = (eff_ic <= 8'd8) || (in_ic_sel >= eff_ic - 8'd8);
        first     = (in_ic_sel == 8'd0);
        slot_ok   = (in_oc_sel >> CH_GROUP_SHIFT) < 8'(MAX_OC_GROUPS);
        slot      = SLOT_WIDTH'(in_oc_sel >> CH_GROUP_SHIFT);
        addr_next = ADDR_WIDTH'((24'(in_h) * 24'(eff_size) + 24'(in_w)) * 24'(oc_groups) + 24'(slot));
        frame_end = (in_h == eff_size - 8'd1) && (in_w == eff_size - 8'd1)
                    && (6'(slot) == oc_groups - 6'd1);
    end

    // Eight identical lanes share the selected slot and the beat's flags.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        point_acc_lane u_lane (
            .acc_prev (acc[slot][k]),
            .lane_val (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .first    (first),
            .relu     (eff_relu),
            .sum      (sum_word[k]),
            .result   (out_word[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Config latch, slot storage, sequence checker and the output register.
    // Out-of-range slots only raise seq_err; they touch no slot and never write.
    // A frame-ending write clears busy even on the beat that set it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ic     <= '0;
            cfg_oc     <= '0;
            cfg_size   <= '0;
            cfg_relu   <= 1'b0;
            busy       <= 1'b0;
            seq_err    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < MAX_OC_GROUPS; i++) begin
                acc[i]         <= '0;
                expected_ic[i] <= '0;
            end
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!busy) begin
                    cfg_ic   <= input_channel;
                    cfg_oc   <= output_channel;
                    cfg_size <= output_size;
                    cfg_relu <= relu_en;
                    busy     <= 1'b1;
                end
                if (!slot_ok) begin
                    seq_err <= 1'b1;
                end else begin
                    if (in_ic_sel != expected_ic[slot])
                        seq_err <= 1'b1;
                    expected_ic[slot] <= last_ic ? 8'd0 : expected_ic[slot] + 8'd8;
                    acc[slot]         <= sum_word;
                    if (last_ic) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_next;
                        wr_data <= out_word;
                        if (frame_end) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_point_accum_writer.sv
// tb_point_accum_writer
//   Directed self-checking bench for point_accum_writer. Inputs change #1
//   after the rising edge; outputs registered by a beat are checked #1 after
//   the edge that consumed it.
module tb_point_accum_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ic_sel, in_oc_sel, in_h, in_w;
    logic [7:0]  input_channel, output_channel, output_size;
    logic        relu_en;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [63:0] wr_data;
    logic        frame_done, busy, seq_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    point_accum_writer dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ic_sel      (in_ic_sel),
        .in_oc_sel      (in_oc_sel),
        .in_h           (in_h),
        .in_w           (in_w),
        .input_channel  (input_channel),
        .output_channel (output_channel),
        .output_size    (output_size),
        .relu_en        (relu_en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .frame_done     (frame_done),
        .busy           (busy),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack8(input int l0, l1, l2, l3, l4, l5, l6, l7);
        logic [63:0] p;
        p[7:0]   = 8'(l0);
        p[15:8]  = 8'(l1);
        p[23:16] = 8'(l2);
        p[31:24] = 8'(l3);
        p[39:32] = 8'(l4);
        p[47:40] = 8'(l5);
        p[55:48] = 8'(l6);
        p[63:56] = 8'(l7);
        return p;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of input, let the DUT consume it, land #1 after the edge.
    task automatic apply_stimulus(input logic v, input logic [7:0] ic, input logic [7:0] oc,
                                  input logic [7:0] h, input logic [7:0] w, input logic [63:0] d);
        in_valid  = v;
        in_ic_sel = ic;
        in_oc_sel = oc;
        in_h      = h;
        in_w      = w;
        in_data   = d;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] ic, input logic [7:0] oc, input logic [7:0] sz, input logic r);
        input_channel  = ic;
        output_channel = oc;
        output_size    = sz;
        relu_en        = r;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
    endtask

    localparam logic [63:0] L1_EXP = 64'hff02_0180_7f00_fd05;

    initial begin
        logic [63:0] l1;
        l1 = pack8(5, -3, 0, 127, -128, 1, 2, -1);
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_ic_sel = '0;
        in_oc_sel = '0;
        in_h = '0;
        in_w = '0;
        set_cfg(8'd8, 8'd8, 8'd2, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check_output("rst_wr_en", 64'(wr_en), 64'd0);
        check_output("rst_wr_addr", 64'(wr_addr), 64'd0);
        check_output("rst_wr_data", wr_data, 64'd0);
        check_output("rst_frame_done", 64'(frame_done), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_seq_err", 64'(seq_err), 64'd0);

        // Single group, 2x2 frame
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(1'b1, 8'd0, 8'd0, 8'(p / 2), 8'(p % 2), l1);
            check_output($sformatf("single_wr_en%0d", p), 64'(wr_en), 64'd1);
            check_output($sformatf("single_addr%0d", p), 64'(wr_addr), 64'(p));
            check_output($sformatf("single_data%0d", p), wr_data, L1_EXP);
            check_output($sformatf("single_done%0d", p), 64'(frame_done), 64'(p == 3));
            check_output($sformatf("single_busy%0d", p), 64'(busy), 64'(p != 3));
        end
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, l1);
        check_output("single_idle_wr_en", 64'(wr_en), 64'd0);
        check_output("single_idle_done", 64'(frame_done), 64'd0);

        // Accumulation with saturation, three input groups
        do_reset();
        set_cfg(8'd24, 8'd8, 8'd1, 1'b0);
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, pack8(100, 0, -60, 0, 0, 0, 0, 0));
        check_output("acc_b1_wr_en", 64'(wr_en), 64'd0);
        apply_stimulus(1'b1, 8'd8, 8'd0, 8'd0, 8'd0, pack8(100, 0, -60, 0, 0, 0, 0, 0));
        check_output("acc_b2_wr_en", 64'(wr_en), 64'd0);
        apply_stimulus(1'b1, 8'd16, 8'd0, 8'd0, 8'd0, pack8(-50, 0, -60, 0, 0, 0, 0, 0));
        check_output("acc_wr_en", 64'(wr_en), 64'd1);
        check_output("acc_data", wr_data, 64'h0000_0000_0080_007f);
        check_output("acc_done", 64'(frame_done), 64'd1);
        check_output("acc_seq_err", 64'(seq_err), 64'd0);

        // Same shape with ReLU
        set_cfg(8'd24, 8'd8, 8'd1, 1'b1);
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, pack8(-20, 30, 0, 0, 0, 0, 0, 0));
        apply_stimulus(1'b1, 8'd8, 8'd0, 8'd0, 8'd0, pack8(-20, 30, 0, 0, 0, 0, 0, 0));
        apply_stimulus(1'b1, 8'd16, 8'd0, 8'd0, 8'd0, pack8(-20, 30, 0, 0, 0, 0, 0, 0));
        check_output("relu_wr_en", 64'(wr_en), 64'd1);
        check_output("relu_data", wr_data, 64'h0000_0000_0000_5a00);

        // Two output slots at pixel (1,0), output_size 3
        do_reset();
        set_cfg(8'd16, 8'd16, 8'd3, 1'b0);
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd1, 8'd0, pack8(10, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(1'b1, 8'd8, 8'd0, 8'd1, 8'd0, pack8(20, 0, 0, 0, 0, 0, 0, 0));
        check_output("slot0_wr_en", 64'(wr_en), 64'd1);
        check_output("slot0_addr", 64'(wr_addr), 64'd6);
        check_output("slot0_data", wr_data, 64'h1e);
        apply_stimulus(1'b1, 8'd0, 8'd8, 8'd1, 8'd0, pack8(-5, 7, 0, 0, 0, 0, 0, 0));
        check_output("slot1_b1_wr_en", 64'(wr_en), 64'd0);
        apply_stimulus(1'b1, 8'd8, 8'd8, 8'd1, 8'd0, pack8(-6, 0, 0, 0, 0, 0, 0, 0));
        check_output("slot1_addr", 64'(wr_addr), 64'd7);
        check_output("slot1_data", wr_data, 64'h07f5);
        check_output("slot1_done", 64'(frame_done), 64'd0);
        check_output("slot1_busy", 64'(busy), 64'd1);

        // Sequence error, sticky through the next frame
        do_reset();
        set_cfg(8'd24, 8'd8, 8'd1, 1'b0);
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, pack8(3, 0, 0, 0, 0, 0, 0, 0));
        check_output("seq_ok", 64'(seq_err), 64'd0);
        apply_stimulus(1'b1, 8'd16, 8'd0, 8'd0, 8'd0, pack8(4, 0, 0, 0, 0, 0, 0, 0));
        check_output("seq_set", 64'(seq_err), 64'd1);
        check_output("seq_data", wr_data, 64'h07);
        check_output("seq_done", 64'(frame_done), 64'd1);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 8'(i * 8), 8'd0, 8'd0, 8'd0, pack8(1, 0, 0, 0, 0, 0, 0, 0));
        check_output("seq_next_data", wr_data, 64'h03);
        check_output("seq_sticky", 64'(seq_err), 64'd1);

        // Reset mid-frame, coinciding with a beat, then replay
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, pack8(50, 0, 0, 0, 0, 0, 0, 0));
        check_output("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        apply_stimulus(1'b1, 8'd8, 8'd0, 8'd0, 8'd0, pack8(50, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        check_output("mid_wr_en", 64'(wr_en), 64'd0);
        check_output("mid_wr_addr", 64'(wr_addr), 64'd0);
        check_output("mid_wr_data", wr_data, 64'd0);
        check_output("mid_done", 64'(frame_done), 64'd0);
        check_output("mid_busy0", 64'(busy), 64'd0);
        check_output("mid_seq_err", 64'(seq_err), 64'd0);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 8'(i * 8), 8'd0, 8'd0, 8'd0, pack8(i + 1, 0, 0, 0, 0, 0, 0, 0));
        check_output("replay_data", wr_data, 64'h06);
        check_output("replay_done", 64'(frame_done), 64'd1);
        check_output("replay_seq_err", 64'(seq_err), 64'd0);

        // Gapped input on the single-group frame
        do_reset();
        set_cfg(8'd8, 8'd8, 8'd2, 1'b0);
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(1'b1, 8'd0, 8'd0, 8'(p / 2), 8'(p % 2), l1);
            check_output($sformatf("gap_wr_en%0d", p), 64'(wr_en), 64'd1);
            check_output($sformatf("gap_addr%0d", p), 64'(wr_addr), 64'(p));
            check_output($sformatf("gap_data%0d", p), wr_data, L1_EXP);
            check_output($sformatf("gap_done%0d", p), 64'(frame_done), 64'(p == 3));
            apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, l1);
            check_output($sformatf("gap_idle_wr_en%0d", p), 64'(wr_en), 64'd0);
            check_output($sformatf("gap_idle_done%0d", p), 64'(frame_done), 64'd0);
        end
        check_output("gap_busy_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
